// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath: widths, opcode encodings,
// instruction-register field positions and immediate decode helpers.
package datapath_pkg;

    localparam int WIDTH     = 32;
    localparam int MEM_WORDS = 512;
    localparam int NUM_REGS  = 16;

    // Instruction-register field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;
    localparam int C_HI   = 18;
    localparam int C2_HI  = 20;
    localparam int C2_LO  = 19;

    typedef enum logic [4:0] {
        OP_LDW  = 5'b00000,
        OP_LDWI = 5'b00001,
        OP_STW  = 5'b00010,
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_SHR  = 5'b00101,
        OP_SHL  = 5'b00110,
        OP_ROR  = 5'b00111,
        OP_ROL  = 5'b01000,
        OP_AND  = 5'b01001,
        OP_OR   = 5'b01010,
        OP_ADDI = 5'b01011,
        OP_ANDI = 5'b01100,
        OP_ORI  = 5'b01101,
        OP_MUL  = 5'b01110,
        OP_DIV  = 5'b01111,
        OP_NEG  = 5'b10000,
        OP_NOT  = 5'b10001
    } opcode_e;

    // Sign-extend the 19-bit constant field of an instruction word.
    function automatic logic [WIDTH-1:0] sign_ext_c(input logic [WIDTH-1:0] ir);
        return {{(WIDTH-1-C_HI){ir[C_HI]}}, ir[C_HI:0]};
    endfunction

    // Opcodes whose second ALU operand is the immediate rather than the bus.
    function automatic logic uses_imm(input logic [4:0] op);
        return op inside {OP_LDW, OP_LDWI, OP_STW, OP_ADDI, OP_ANDI, OP_ORI};
    endfunction

endpackage

// File: rtl/datapath_if.sv
// Control-strobe bundle between the control unit (master) and the datapath
// (slave), plus the external in/out port data.
interface datapath_if;
    import datapath_pkg::*;

    logic             IncPC, CONin, Cin, branch_flag;
    logic             RAM_write, MDR_read;
    logic             MDR_enable, MAR_enable, IR_enable, Y_enable, PC_enable;
    logic             HI_enable, LO_enable, ZHighIn, ZLowIn, OutPort_enable;
    logic             Gra, Grb, Grc, R_in, R_out, BAout;
    logic             MDRout, PCout, ZLowout, ZHighout, HIout, LOout, Yout;
    logic             InPortout, Cout;
    logic [WIDTH-1:0] InPort_input;
    logic [WIDTH-1:0] OutPort_output;

    modport master (
        output IncPC, CONin, Cin, branch_flag, RAM_write, MDR_read,
               MDR_enable, MAR_enable, IR_enable, Y_enable, PC_enable,
               HI_enable, LO_enable, ZHighIn, ZLowIn, OutPort_enable,
               Gra, Grb, Grc, R_in, R_out, BAout,
               MDRout, PCout, ZLowout, ZHighout, HIout, LOout, Yout,
               InPortout, Cout, InPort_input,
        input  OutPort_output
    );

    modport slave (
        input  IncPC, CONin, Cin, branch_flag, RAM_write, MDR_read,
               MDR_enable, MAR_enable, IR_enable, Y_enable, PC_enable,
               HI_enable, LO_enable, ZHighIn, ZLowIn, OutPort_enable,
               Gra, Grb, Grc, R_in, R_out, BAout,
               MDRout, PCout, ZLowout, ZHighout, HIout, LOout, Yout,
               InPortout, Cout, InPort_input,
        output OutPort_output
    );

endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus or the immediate.
// Produces a 64-bit result; the high half is only nonzero for mul and div.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   bus_i,
    input  logic [WIDTH-1:0]   c_i,
    input  logic [4:0]         opcode_i,
    input  logic               inc_pc_i,
    input  logic               cin_i,
    output logic [2*WIDTH-1:0] result_o
);

    logic [WIDTH-1:0]          b_op;
    logic [4:0]                sh;
    logic [5:0]                sh_inv;
    logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH-1:0]          quot, rem;
    logic [WIDTH-1:0]          lo, hi;

    assign b_op   = uses_imm(opcode_i) ? c_i : bus_i;
    assign sh     = b_op[4:0];
    assign sh_inv = 6'(WIDTH) - {1'b0, sh};

    // Division runs at double width so the most-negative / -1 case cannot overflow.
    assign a_ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_ext = {{WIDTH{b_op[WIDTH-1]}}, b_op};
    assign prod  = a_ext * b_ext;
    assign quot  = (b_op == '0) ? '0 : WIDTH'(a_ext / b_ext);
    assign rem   = (b_op == '0) ? '0 : WIDTH'(a_ext % b_ext);

    // Opcode decode; IncPC overrides everything for PC increment
    always_comb begin
        // NOTE: defaults first so every path assigns lo/hi and no latch is inferred.
        hi = '0;
        lo = a_i + b_op;
        if (inc_pc_i) begin
            lo = bus_i + WIDTH'(1);
        end else begin
            case (opcode_i)
                OP_ADD:  lo = a_i + b_op + WIDTH'(cin_i);
                OP_SUB:  lo = a_i - b_op;
                OP_SHR:  lo = a_i >> sh;
                OP_SHL:  lo = a_i << sh;
                OP_ROR:  lo = (a_i >> sh) | (a_i << sh_inv);
                OP_ROL:  lo = (a_i << sh) | (a_i >> sh_inv);
                OP_AND,
                OP_ANDI: lo = a_i & b_op;
                OP_OR,
                OP_ORI:  lo = a_i | b_op;
                OP_MUL: begin
                    hi = prod[2*WIDTH-1:WIDTH];
                    lo = prod[WIDTH-1:0];
                end
                OP_DIV: begin
                    hi = rem;
                    lo = quot;
                end
                OP_NEG:  lo = -b_op;
                OP_NOT:  lo = ~b_op;
                default: ;
            endcase
        end
    end

    assign result_o = {hi, lo};

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, PC, IR, MAR, MDR, RAM, Y,
// ALU, 64-bit Z, HI/LO, CON and in/out ports, sequenced by external strobes.
module datapath
    import datapath_pkg::*;
#(
    parameter int MEM_WORDS = datapath_pkg::MEM_WORDS,
    parameter int WIDTH     = datapath_pkg::WIDTH
) (
    input  logic      Clock,
    input  logic      Clear,
    datapath_if.slave ctl
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [WIDTH-1:0]   reg_q [NUM_REGS];
    logic [WIDTH-1:0]   ram_q [MEM_WORDS];
    logic [WIDTH-1:0]   pc_q, ir_q, mar_q, mdr_q, y_q;
    logic [WIDTH-1:0]   zhi_q, zlo_q, hi_q, lo_q, in_q, out_q;
    logic               con_q;

    logic [WIDTH-1:0]   bus, c_ext, ram_rdata, mdr_d;
    logic [2*WIDTH-1:0] alu_res;
    logic [3:0]         ra, rb, rc, reg_sel;
    logic [1:0]         c2;
    logic               con_d, pc_load;
    logic               unused_mar;

    // Instruction field decode
    assign ra    = ir_q[RA_HI:RA_LO];
    assign rb    = ir_q[RB_HI:RB_LO];
    assign rc    = ir_q[RC_HI:RC_LO];
    assign c2    = ir_q[C2_HI:C2_LO];
    assign c_ext = sign_ext_c(ir_q);

    // Register select priority: Gra > Grb > Grc
    assign reg_sel = ctl.Gra ? ra :
                     ctl.Grb ? rb :
                     ctl.Grc ? rc : 4'd0;

    assign ram_rdata  = ram_q[mar_q[AW-1:0]];
    assign unused_mar = ^mar_q[WIDTH-1:AW];

    // Single shared bus: fixed-priority source mux, zero when idle
    always_comb begin
        bus = '0;
        if      (ctl.MDRout)    bus = mdr_q;
        else if (ctl.PCout)     bus = pc_q;
        else if (ctl.ZLowout)   bus = zlo_q;
        else if (ctl.ZHighout)  bus = zhi_q;
        else if (ctl.HIout)     bus = hi_q;
        else if (ctl.LOout)     bus = lo_q;
        else if (ctl.Yout)      bus = y_q;
        else if (ctl.InPortout) bus = in_q;
        else if (ctl.Cout)      bus = c_ext;
        else if (ctl.R_out)     bus = reg_q[reg_sel];
        else if (ctl.BAout)     bus = (reg_sel == 4'd0) ? '0 : reg_q[reg_sel];
    end

    // Branch condition evaluated on the current bus value, selected by C2
    always_comb begin
        con_d = 1'b0;
        case (c2)
            2'b00: con_d = (bus == '0);
            2'b01: con_d = (bus != '0);
            2'b10: con_d = ~bus[WIDTH-1];
            2'b11: con_d = bus[WIDTH-1];
            default: ;
        endcase
    end

    assign mdr_d   = ctl.MDR_read ? ram_rdata : bus;
    assign pc_load = ctl.PC_enable && (!ctl.branch_flag || con_q);

    datapath_alu u_alu (
        .a_i      (y_q),
        .bus_i    (bus),
        .c_i      (c_ext),
        .opcode_i (ir_q[OPC_HI:OPC_LO]),
        .inc_pc_i (ctl.IncPC),
        .cin_i    (ctl.Cin),
        .result_o (alu_res)
    );

    // Special-purpose registers: each loads on its strobe, otherwise holds
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            in_q  <= '0;
            out_q <= '0;
            con_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so a register driving the bus while loading
            // still presents its old value for the whole cycle.
            in_q <= ctl.InPort_input;
            if (pc_load)            pc_q  <= bus;
            if (ctl.IR_enable)      ir_q  <= bus;
            if (ctl.MAR_enable)     mar_q <= bus;
            if (ctl.MDR_enable)     mdr_q <= mdr_d;
            if (ctl.Y_enable)       y_q   <= bus;
            if (ctl.ZHighIn)        zhi_q <= alu_res[2*WIDTH-1:WIDTH];
            if (ctl.ZLowIn)         zlo_q <= alu_res[WIDTH-1:0];
            if (ctl.HI_enable)      hi_q  <= bus;
            if (ctl.LO_enable)      lo_q  <= bus;
            if (ctl.OutPort_enable) out_q <= bus;
            if (ctl.CONin)          con_q <= con_d;
        end
    end

    // General-purpose register file R0-R15; R0 is a real, writable register
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
        end else if (ctl.R_in) begin
            reg_q[reg_sel] <= bus;
        end
    end

    // RAM write port: MDR stored at MAR
    // NOTE: RAM has no reset so it maps onto block memory and survives Clear.
    always_ff @(posedge Clock) begin
        if (ctl.RAM_write) ram_q[mar_q[AW-1:0]] <= mdr_q;
    end

    assign ctl.OutPort_output = out_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for the single-bus datapath. Internal state is observed
// black-box by routing each source onto the bus and into the out-port.
module tb_datapath;

    logic Clock = 1'b0;
    logic Clear = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    datapath_if dif ();

    datapath dut (
        .Clock (Clock),
        .Clear (Clear),
        .ctl   (dif)
    );

    always #5 Clock = ~Clock;

    // ------------------------------------------------------------------
    // Reference ALU built from the opcode table with plain arithmetic.
    // ------------------------------------------------------------------
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] bus, input logic [31:0] ir,
                                            input logic inc, input logic cin);
        logic [31:0] c, b, lo, hi;
        logic [63:0] dbl;
        longint      sa, sb, p;
        c  = {{13{ir[18]}}, ir[18:0]};
        b  = (op inside {5'd0, 5'd1, 5'd2, 5'd11, 5'd12, 5'd13}) ? c : bus;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'h0;
        if (inc) return {32'h0, bus + 32'd1};
        case (op)
            5'd3:  lo = a + b + {31'b0, cin};
            5'd4:  lo = a - b;
            5'd5:  lo = a >> b[4:0];
            5'd6:  lo = a << b[4:0];
            5'd7:  begin dbl = {a, a} >> b[4:0]; lo = dbl[31:0];  end
            5'd8:  begin dbl = {a, a} << b[4:0]; lo = dbl[63:32]; end
            5'd9, 5'd12:  lo = a & b;
            5'd10, 5'd13: lo = a | b;
            5'd14: begin p = sa * sb; {hi, lo} = p; end
            5'd15: begin
                if (b == 32'h0) lo = 32'h0;
                else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
            end
            5'd16: lo = 32'h0 - b;
            5'd17: lo = ~b;
            default: lo = a + b;
        endcase
        return {hi, lo};
    endfunction

    function automatic logic ref_con(input logic [1:0] c2, input logic [31:0] v);
        case (c2)
            2'd0:    return v == 32'h0;
            2'd1:    return v != 32'h0;
            2'd2:    return v[31] == 1'b0;
            default: return v[31] == 1'b1;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (drive after posedge+1, sample at posedge+1)
    // ------------------------------------------------------------------
    task automatic idle();
        dif.IncPC = 0; dif.CONin = 0; dif.Cin = 0; dif.branch_flag = 0;
        dif.RAM_write = 0; dif.MDR_read = 0; dif.MDR_enable = 0; dif.MAR_enable = 0;
        dif.IR_enable = 0; dif.Y_enable = 0; dif.PC_enable = 0; dif.HI_enable = 0;
        dif.LO_enable = 0; dif.ZHighIn = 0; dif.ZLowIn = 0; dif.OutPort_enable = 0;
        dif.Gra = 0; dif.Grb = 0; dif.Grc = 0; dif.R_in = 0; dif.R_out = 0; dif.BAout = 0;
        dif.MDRout = 0; dif.PCout = 0; dif.ZLowout = 0; dif.ZHighout = 0; dif.HIout = 0;
        dif.LOout = 0; dif.Yout = 0; dif.InPortout = 0; dif.Cout = 0;
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
        idle();
    endtask

    // Present a value at the in-port; it is on the in-port register next cycle.
    task automatic put(input logic [31:0] v);
        dif.InPort_input = v;
        cyc();
    endtask

    // Capture whatever the caller has put on the bus into the out-port.
    task automatic read_bus(output logic [31:0] v);
        dif.OutPort_enable = 1;
        cyc();
        v = dif.OutPort_output;
    endtask

    task automatic ld_ir(input logic [31:0] v);
        put(v);
        dif.InPortout = 1; dif.IR_enable = 1;
        cyc();
    endtask

    task automatic ld_reg(input logic [3:0] n, input logic [31:0] v);
        ld_ir({5'b0, n, 23'b0});
        put(v);
        dif.InPortout = 1; dif.Gra = 1; dif.R_in = 1;
        cyc();
    endtask

    task automatic read_reg(input logic [3:0] n, output logic [31:0] v);
        ld_ir({5'b0, n, 23'b0});
        dif.Gra = 1; dif.R_out = 1;
        read_bus(v);
    endtask

    task automatic ram_store(input logic [31:0] addr, input logic [31:0] v);
        put(addr); dif.InPortout = 1; dif.MAR_enable = 1; cyc();
        put(v);    dif.InPortout = 1; dif.MDR_enable = 1; cyc();
        dif.RAM_write = 1; cyc();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] got;
        string       names [8] = '{"PC", "C", "ZLO", "ZHI", "Y", "HI", "LO", "MDR"};
        ld_reg(4'd5, 32'h1234_5678);
        put(32'hAB);
        dif.InPortout = 1; dif.PC_enable = 1; dif.Y_enable = 1; dif.HI_enable = 1;
        dif.LO_enable = 1; dif.MDR_enable = 1; dif.OutPort_enable = 1;
        cyc();
        dif.ZLowIn = 1; dif.ZHighIn = 1;
        cyc();
        got = dif.OutPort_output;
        if (got !== 32'hAB) begin n_miss++; $display("FAIL pre_reset_out: got %h expected %h", got, 32'hAB); end
        n_vec++;
        #2 Clear = 1;
        #1;
        got = dif.OutPort_output;
        if (got !== 32'h0) begin n_miss++; $display("FAIL async_clear_out: got %h expected 0", got); end
        n_vec++;
        #1 Clear = 0;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: dif.PCout = 1;
                1: dif.Cout = 1;
                2: dif.ZLowout = 1;
                3: dif.ZHighout = 1;
                4: dif.Yout = 1;
                5: dif.HIout = 1;
                6: dif.LOout = 1;
                default: dif.MDRout = 1;
            endcase
            read_bus(got);
            if (got !== 32'h0) begin n_miss++; $display("FAIL reset_%s: got %h expected 0", names[k], got); end
            n_vec++;
        end
        for (int n = 0; n < 16; n++) begin
            read_reg(4'(n), got);
            if (got !== 32'h0) begin n_miss++; $display("FAIL reset_R%0d: got %h expected 0", n, got); end
            n_vec++;
        end
    endtask

    task automatic test_fetch();
        logic [31:0] got;
        ram_store(32'h0, 32'h0088_0005);
        put(32'h0); dif.InPortout = 1; dif.PC_enable = 1; cyc();
        dif.PCout = 1; dif.MAR_enable = 1; dif.IncPC = 1; dif.ZLowIn = 1; cyc();
        dif.MDR_read = 1; dif.MDR_enable = 1; dif.ZLowout = 1; dif.PC_enable = 1; cyc();
        dif.MDRout = 1; dif.IR_enable = 1; cyc();
        dif.Cout = 1; read_bus(got);
        if (got !== 32'h5) begin n_miss++; $display("FAIL fetch_ir_c: got %h expected %h", got, 32'h5); end
        n_vec++;
        dif.PCout = 1; read_bus(got);
        if (got !== 32'h1) begin n_miss++; $display("FAIL fetch_pc: got %h expected %h", got, 32'h1); end
        n_vec++;
    endtask

    // Runs with IR = ldw R1,5(R1) left by the fetch.
    task automatic test_ld();
        logic [31:0] got;
        ram_store(32'h10, 32'h1111_1111);
        ram_store(32'h15, 32'hDEAD_BEEF);
        put(32'h10); dif.InPortout = 1; dif.Gra = 1; dif.R_in = 1; cyc();
        dif.Grb = 1; dif.BAout = 1; dif.Y_enable = 1; cyc();
        dif.ZLowIn = 1; cyc();
        dif.ZLowout = 1; dif.MAR_enable = 1; cyc();
        dif.MDR_read = 1; dif.MDR_enable = 1; cyc();
        dif.Gra = 1; dif.R_in = 1; dif.MDRout = 1; cyc();
        dif.Gra = 1; dif.R_out = 1; read_bus(got);
        if (got !== 32'hDEAD_BEEF) begin n_miss++; $display("FAIL ld_r1: got %h expected %h", got, 32'hDEAD_BEEF); end
        n_vec++;
        dif.ZLowout = 1; read_bus(got);
        if (got !== 32'h15) begin n_miss++; $display("FAIL ld_addr: got %h expected %h", got, 32'h15); end
        n_vec++;
        // Overwrite RAM through the MAR left by the load, then fetch address 0x15.
        put(32'h5A5A); dif.InPortout = 1; dif.MDR_enable = 1; cyc();
        dif.RAM_write = 1; cyc();
        put(32'h15); dif.InPortout = 1; dif.MAR_enable = 1; cyc();
        dif.MDR_read = 1; dif.MDR_enable = 1; cyc();
        dif.MDRout = 1; read_bus(got);
        if (got !== 32'h5A5A) begin n_miss++; $display("FAIL ld_mar: got %h expected %h", got, 32'h5A5A); end
        n_vec++;
    endtask

    task automatic test_r0();
        logic [31:0] got;
        ld_reg(4'd0, 32'h7);
        dif.Grb = 1; dif.BAout = 1; dif.Y_enable = 1; cyc();
        dif.Yout = 1; read_bus(got);
        if (got !== 32'h0) begin n_miss++; $display("FAIL r0_baout: got %h expected 0", got); end
        n_vec++;
        dif.Grb = 1; dif.R_out = 1; dif.Y_enable = 1; cyc();
        dif.Yout = 1; read_bus(got);
        if (got !== 32'h7) begin n_miss++; $display("FAIL r0_rout: got %h expected %h", got, 32'h7); end
        n_vec++;
    endtask

    task automatic test_mul_div();
        logic [31:0] ys  [3] = '{32'hFFFF_FFFE, 32'h7, 32'h7};
        logic [31:0] bs  [3] = '{32'h3, 32'h2, 32'h0};
        logic [31:0] irs [3] = '{32'h7000_0000, 32'h7800_0000, 32'h7800_0000};
        logic [31:0] elo [3] = '{32'hFFFF_FFFA, 32'h3, 32'h0};
        logic [31:0] ehi [3] = '{32'hFFFF_FFFF, 32'h1, 32'h0};
        logic [31:0] got;
        for (int k = 0; k < 3; k++) begin
            ld_ir(irs[k]);
            put(ys[k]); dif.InPortout = 1; dif.Y_enable = 1; cyc();
            put(bs[k]); dif.InPortout = 1; dif.ZHighIn = 1; dif.ZLowIn = 1; cyc();
            dif.ZLowout = 1; read_bus(got);
            if (got !== elo[k]) begin n_miss++; $display("FAIL muldiv%0d_lo: got %h expected %h", k, got, elo[k]); end
            n_vec++;
            dif.ZHighout = 1; read_bus(got);
            if (got !== ehi[k]) begin n_miss++; $display("FAIL muldiv%0d_hi: got %h expected %h", k, got, ehi[k]); end
            n_vec++;
        end
    endtask

    task automatic test_branch();
        logic [31:0] got;
        ld_ir(32'h0);
        put(32'h0); dif.InPortout = 1; dif.CONin = 1; cyc();
        put(32'h40); dif.InPortout = 1; dif.PC_enable = 1; dif.branch_flag = 1; cyc();
        dif.PCout = 1; read_bus(got);
        if (got !== 32'h40) begin n_miss++; $display("FAIL branch_taken: got %h expected %h", got, 32'h40); end
        n_vec++;
        put(32'h5); dif.InPortout = 1; dif.CONin = 1; cyc();
        put(32'h80); dif.InPortout = 1; dif.PC_enable = 1; dif.branch_flag = 1; cyc();
        dif.PCout = 1; read_bus(got);
        if (got !== 32'h40) begin n_miss++; $display("FAIL branch_not_taken: got %h expected %h", got, 32'h40); end
        n_vec++;
        put(32'hA5); dif.InPortout = 1; dif.OutPort_enable = 1; cyc();
        got = dif.OutPort_output;
        if (got !== 32'hA5) begin n_miss++; $display("FAIL outport: got %h expected %h", got, 32'hA5); end
        n_vec++;
    endtask

    task automatic test_con_random();
        logic [31:0] got, v, tgt, m_pc;
        logic [1:0]  c2;
        logic        m_con;
        m_pc = 32'h100;
        put(m_pc); dif.InPortout = 1; dif.PC_enable = 1; cyc();
        for (int it = 0; it < 16; it++) begin
            c2 = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: v = 32'h0;
                1: v = $urandom() | 32'h8000_0000;
                2: v = $urandom() & 32'h7FFF_FFFF;
                default: v = $urandom();
            endcase
            ld_ir({11'b0, c2, 19'b0});
            put(v); dif.InPortout = 1; dif.CONin = 1; cyc();
            m_con = ref_con(c2, v);
            tgt = $urandom();
            put(tgt); dif.InPortout = 1; dif.PC_enable = 1; dif.branch_flag = 1; cyc();
            if (m_con) m_pc = tgt;
            dif.PCout = 1; read_bus(got);
            if (got !== m_pc) begin n_miss++; $display("FAIL con_pc it%0d c2=%0d v=%h: got %h expected %h", it, c2, v, got, m_pc); end
            n_vec++;
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] got, a, b, ir;
        logic [63:0] exp;
        logic        inc, cin;
        for (int it = 0; it < 48; it++) begin
            ir  = {5'($urandom_range(0, 19)), 27'($urandom())};
            a   = $urandom();
            b   = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
            inc = ($urandom_range(0, 7) == 0);
            cin = 1'($urandom_range(0, 1));
            ld_ir(ir);
            put(a); dif.InPortout = 1; dif.Y_enable = 1; cyc();
            put(b); dif.InPortout = 1; dif.ZHighIn = 1; dif.ZLowIn = 1; dif.IncPC = inc; dif.Cin = cin; cyc();
            exp = ref_alu(ir[31:27], a, b, ir, inc, cin);
            dif.ZLowout = 1; read_bus(got);
            if (got !== exp[31:0]) begin n_miss++; $display("FAIL alu_lo op=%0d a=%h b=%h inc=%0d: got %h expected %h", ir[31:27], a, b, inc, got, exp[31:0]); end
            n_vec++;
            dif.ZHighout = 1; read_bus(got);
            if (got !== exp[63:32]) begin n_miss++; $display("FAIL alu_hi op=%0d a=%h b=%h inc=%0d: got %h expected %h", ir[31:27], a, b, inc, got, exp[63:32]); end
            n_vec++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        ram_store(32'h33, 32'hCAFE_0033);
        put(32'h1111); dif.InPortout = 1; dif.MDR_enable = 1; cyc();
        put(32'h2222); dif.InPortout = 1; dif.PC_enable = 1; cyc();
        put(32'h3333); dif.InPortout = 1; dif.Y_enable = 1; cyc();
        dif.MDRout = 1; dif.PCout = 1; dif.Yout = 1; dif.InPortout = 1; read_bus(got);
        if (got !== 32'h1111) begin n_miss++; $display("FAIL prio_mdr: got %h expected %h", got, 32'h1111); end
        n_vec++;
        dif.PCout = 1; dif.Yout = 1; dif.Cout = 1; read_bus(got);
        if (got !== 32'h2222) begin n_miss++; $display("FAIL prio_pc: got %h expected %h", got, 32'h2222); end
        n_vec++;
        read_bus(got);
        if (got !== 32'h0) begin n_miss++; $display("FAIL idle_bus: got %h expected 0", got); end
        n_vec++;
        // MDR drives its old value while capturing RAM[MAR] in the same cycle.
        dif.MDRout = 1; dif.MDR_read = 1; dif.MDR_enable = 1; read_bus(got);
        if (got !== 32'h1111) begin n_miss++; $display("FAIL mdr_old_drive: got %h expected %h", got, 32'h1111); end
        n_vec++;
        dif.MDRout = 1; read_bus(got);
        if (got !== 32'hCAFE_0033) begin n_miss++; $display("FAIL mdr_new_load: got %h expected %h", got, 32'hCAFE_0033); end
        n_vec++;
    endtask

    initial begin
        idle();
        dif.InPort_input = 32'h0;
        repeat (2) @(posedge Clock);
        #1 Clear = 0;
        test_reset();
        test_fetch();
        test_ld();
        test_r0();
        test_mul_div();
        test_branch();
        test_con_random();
        test_alu_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
